// File: rtl/frida_spi_master.sv
// frida_spi_master: streams an NBITS-bit configuration register to the FRIDA
// chip over SPI, MSB first. The register is loaded as 32-bit words.
// Define FRIDA_SPI_READBACK_EN to build in the RX capture buffer that is
// readable through rd_addr/rd_data. Without it, rd_data is tied to zero.
module frida_spi_master #(
  parameter int unsigned NBITS   = 1280,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [5:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        spi_sclk,
  output logic        spi_sdi,
  input  logic        spi_sdo,
  output logic        spi_cs_b
);

  localparam int unsigned NWORDS = NBITS / 32;
  localparam int unsigned BW     = $clog2(NBITS + 1);
  localparam int unsigned DW     = $clog2(CLK_DIV + 1);
  localparam int unsigned IW     = $clog2(NBITS);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div_cnt, div_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic             sclk_n, sdi_n, cs_b_n, busy_n, done_n;
  logic             div_last_c;
  logic             capture_c;
  logic [IW-1:0]    next_idx_c;
  logic [IW-1:0]    cap_idx_c;
  logic [NBITS-1:0] tx_q;

  assign div_last_c = (div_cnt == DW'(CLK_DIV - 1));
  assign next_idx_c = IW'(NBITS - 2) - IW'(bit_cnt);
  assign cap_idx_c  = IW'(NBITS - 1) - IW'(bit_cnt);

  // State, counters and SPI/status outputs; reset aborts with cs_b high, sclk low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      spi_sclk <= 1'b0;
      spi_sdi  <= 1'b0;
      spi_cs_b <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_cnt  <= bit_n;
      spi_sclk <= sclk_n;
      spi_sdi  <= sdi_n;
      spi_cs_b <= cs_b_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state logic: setup, 2*NBITS clock phases, hold, one-cycle done.
  always_comb begin
    state_n   = state;
    div_n     = div_cnt;
    bit_n     = bit_cnt;
    sclk_n    = spi_sclk;
    sdi_n     = spi_sdi;
    cs_b_n    = spi_cs_b;
    busy_n    = busy;
    done_n    = 1'b0;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETUP;
          div_n   = '0;
          bit_n   = '0;
          busy_n  = 1'b1;
          cs_b_n  = 1'b0;
          sclk_n  = 1'b0;
          sdi_n   = tx_q[NBITS-1];
        end
      end
      SETUP: begin
        if (div_last_c) begin
          state_n = SHIFT;
          div_n   = '0;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      SHIFT: begin
        // Sample sdo during the first high cycle of each bit.
        capture_c = spi_sclk && (div_cnt == '0);
        if (!div_last_c) begin
          div_n = div_cnt + DW'(1);
        end else begin
          div_n = '0;
          if (!spi_sclk) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            bit_n  = bit_cnt + BW'(1);
            if (bit_cnt == BW'(NBITS - 1)) begin
              state_n = HOLD;
            end else begin
              sdi_n = tx_q[next_idx_c];
            end
          end
        end
      end
      HOLD: begin
        if (div_last_c) begin
          state_n = DONE;
          div_n   = '0;
          busy_n  = 1'b0;
          cs_b_n  = 1'b1;
          sdi_n   = 1'b0;
          done_n  = 1'b1;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        bit_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // TX buffer word writes; blocked while a transaction runs. Not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && !busy) begin
      for (int k = 0; k < int'(NWORDS); k++) begin
        if (wr_addr == 6'(k)) tx_q[k*32 +: 32] <= wr_data;
      end
    end
  end

`ifdef FRIDA_SPI_READBACK_EN
  logic [NBITS-1:0] rx_q;

  // RX capture: n-th received bit lands at RX bit NBITS-1-n. Not reset.
  always_ff @(posedge clk) begin
    if (!rst && capture_c) rx_q[cap_idx_c] <= spi_sdo;
  end

  // Combinational word read of the RX buffer; out-of-range reads return 0.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < int'(NWORDS); k++) begin
      if (rd_addr == 6'(k)) rd_data = rx_q[k*32 +: 32];
    end
  end
`else
  logic unused_rx;

  assign rd_data   = '0;
  assign unused_rx = ^{spi_sdo, rd_addr, capture_c, cap_idx_c};
`endif

endmodule

// File: tb/tb_frida_spi_master.sv
// tb_frida_spi_master: randomized scoreboard bench for frida_spi_master.
// Instance A runs at CLK_DIV=1, instance B at CLK_DIV=4 for phase timing.
// Readback expectations follow FRIDA_SPI_READBACK_EN.
module tb_frida_spi_master;

  localparam int unsigned NBITS  = 1280;
  localparam int unsigned NW     = NBITS / 32;
  localparam int unsigned DIV_A  = 1;
  localparam int unsigned DIV_B  = 4;
  localparam int          BUSY_A = DIV_A * (2 * NBITS + 2);
  localparam int          BUDGET = 20000;
`ifdef FRIDA_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wr_en, start, spi_sdo;
  logic [5:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic        busy, done, spi_sclk, spi_sdi, spi_cs_b;

  logic        b_rst, b_wr_en, b_start, b_sdo;
  logic [5:0]  b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data, b_rd_data;
  logic        b_busy, b_done, b_sclk, b_sdi, b_cs_b;

  always #5 clk = ~clk;

  frida_spi_master #(.NBITS(NBITS), .CLK_DIV(DIV_A)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .busy(busy), .done(done),
    .spi_sclk(spi_sclk), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .spi_cs_b(spi_cs_b)
  );

  frida_spi_master #(.NBITS(NBITS), .CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .start(b_start), .busy(b_busy), .done(b_done),
    .spi_sclk(b_sclk), .spi_sdi(b_sdi), .spi_sdo(b_sdo), .spi_cs_b(b_cs_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: register contents as words, chip output pattern, expected streams.
  logic [31:0]      model_a [NW];
  logic [31:0]      model_b [NW];
  logic [NBITS-1:0] slave_a;
  logic [NBITS-1:0] exp_a_q[$];
  logic [NBITS-1:0] exp_b_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_stream(input string name, input logic [NBITS-1:0] got,
                              input logic [NBITS-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      for (int k = NW - 1; k >= 0; k--) begin
        if (got[k*32 +: 32] !== exp[k*32 +: 32]) begin
          $display("FAIL %s: word %0d got 0x%08h expected 0x%08h", name, k,
                   got[k*32 +: 32], exp[k*32 +: 32]);
          break;
        end
      end
    end
  endtask

  // Word k occupies register bits [32k+31:32k]; the chip sees bit NBITS-1 first.
  function automatic logic [NBITS-1:0] pack_words(input logic [31:0] m [NW]);
    logic [NBITS-1:0] s;
    for (int k = 0; k < int'(NW); k++) s[k*32 +: 32] = m[k];
    return s;
  endfunction

  // Monitor A: assembles the MSB-first stream and drives the chip's sdo.
  logic [NBITS-1:0] got_a, sdo_sh;
  int rises_a, busy_cyc_a;
  bit sclk_prev_a, done_prev_a, sdi_bad_a;
  always @(negedge clk) begin
    if (rst) begin
      got_a = '0; rises_a = 0; busy_cyc_a = 0; sclk_prev_a = 1'b0; done_prev_a = 1'b0;
      sdo_sh = slave_a; spi_sdo = sdo_sh[NBITS-1];
    end else begin
      if (spi_cs_b && spi_sdi) sdi_bad_a = 1'b1;
      if (busy) busy_cyc_a++;
      if (!spi_cs_b && spi_sclk && !sclk_prev_a) begin
        got_a = {got_a[NBITS-2:0], spi_sdi};
        rises_a++;
      end
      if (spi_cs_b) sdo_sh = slave_a;
      else if (!spi_sclk && sclk_prev_a) sdo_sh = sdo_sh << 1;
      spi_sdo = sdo_sh[NBITS-1];
      if (done) begin
        if (exp_a_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL done_a: unexpected done pulse at %0t", $time);
        end else begin
          check_stream("stream_a", got_a, exp_a_q.pop_front());
        end
        check("busy_len_a", 32'(busy_cyc_a), 32'(BUSY_A));
        check("rises_a", 32'(rises_a), 32'(NBITS));
        check("done_pulse_a", 32'(done_prev_a), 32'd0);
        check("sdi_idle_a", 32'(sdi_bad_a), 32'd0);
        got_a = '0; rises_a = 0; busy_cyc_a = 0;
      end
      done_prev_a = done;
      sclk_prev_a = spi_sclk;
    end
  end

  // Monitor B: phase lengths, sdi setup stability before each rise, stream.
  logic [NBITS-1:0] got_b;
  int rises_b, run_b, stable_b, hi_bad_b, lo_bad_b, sdi_early_b;
  bit sclk_prev_b, sdi_prev_b;
  always @(negedge clk) begin
    b_sdo = 1'($urandom);
    if (b_rst) begin
      got_b = '0; rises_b = 0; run_b = 0; stable_b = 0;
      hi_bad_b = 0; lo_bad_b = 0; sdi_early_b = 0; sclk_prev_b = 1'b0; sdi_prev_b = 1'b0;
    end else if (b_cs_b) begin
      if (b_done) begin
        if (exp_b_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL done_b: unexpected done pulse at %0t", $time);
        end else begin
          check_stream("stream_b", got_b, exp_b_q.pop_front());
        end
        check("hold_len_b", 32'(run_b), 32'(DIV_B));
        check("high_phase_b", 32'(hi_bad_b), 32'd0);
        check("low_phase_b", 32'(lo_bad_b), 32'd0);
        check("sdi_setup_b", 32'(sdi_early_b), 32'd0);
        check("rises_b", 32'(rises_b), 32'(NBITS));
        got_b = '0; rises_b = 0; hi_bad_b = 0; lo_bad_b = 0; sdi_early_b = 0;
      end
      run_b = 0; stable_b = 0; sclk_prev_b = 1'b0; sdi_prev_b = 1'b0;
    end else begin
      if (b_sclk != sclk_prev_b) begin
        if (sclk_prev_b && run_b != int'(DIV_B)) hi_bad_b++;
        if (!sclk_prev_b && rises_b > 0 && run_b != int'(DIV_B)) lo_bad_b++;
        if (!sclk_prev_b && rises_b == 0 && run_b != int'(2 * DIV_B)) lo_bad_b++;
        run_b = 1;
      end else begin
        run_b++;
      end
      if (b_sdi != sdi_prev_b) stable_b = 1;
      else stable_b++;
      if (b_sclk && !sclk_prev_b) begin
        if (stable_b <= int'(DIV_B)) sdi_early_b++;
        got_b = {got_b[NBITS-2:0], b_sdi};
        rises_b++;
      end
      sclk_prev_b = b_sclk;
      sdi_prev_b  = b_sdi;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [5:0] a, input logic [31:0] d, input bit take);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (take && a < 6'(NW)) model_a[a] = d;
  endtask

  task automatic start_a(input bit expect_run);
    if (expect_run) exp_a_q.push_back(pack_words(model_a));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done && n < BUDGET) begin
      tick();
      n++;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout_a: no done within %0d cycles", BUDGET);
    end
  endtask

  task automatic run_a();
    start_a(1'b1);
    check("first_busy_a", 32'(busy), 32'd1);
    check("first_csb_a", 32'(spi_cs_b), 32'd0);
    check("first_sdi_a", 32'(spi_sdi), 32'(model_a[NW-1][31]));
    wait_done_a();
    tick();
  endtask

  task automatic readback_a();
    logic [31:0] w;
    for (int a = 0; a < 64; a++) begin
      if (a < int'(NW) || a % 8 == 0 || a == 63) begin
        rd_addr = 6'(a);
        #1;
        w = (RB && a < int'(NW)) ? 32'(slave_a >> (a * 32)) : 32'd0;
        check($sformatf("rd_data[%0d]", a), rd_data, w);
      end
    end
  endtask

  task automatic randomize_tx_a();
    for (int k = 0; k < int'(NW); k++) write_a(6'(k), $urandom, 1'b1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    b_rst = 1'b1; b_wr_en = 1'b0; b_start = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
    sdi_bad_a = 1'b0;
    for (int k = 0; k < int'(NW); k++) begin model_a[k] = '0; model_b[k] = '0; end
    for (int k = 0; k < int'(NW); k++) slave_a[k*32 +: 32] = $urandom;
    start = 1'b1; wr_en = 1'b1;
    repeat (3) tick();
    start = 1'b0; wr_en = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_csb", 32'(spi_cs_b), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_sdi", 32'(spi_sdi), 32'd0);
    rst = 1'b0; b_rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single set bit in word 39: sdi=1 then 1279 zeros; sdo random.
    for (int k = 0; k < int'(NW); k++) write_a(6'(k), 32'd0, 1'b1);
    write_a(6'd39, 32'h8000_0000, 1'b1);
    run_a();
    readback_a();

    // Chip returns 0xA5A5A5A5 in every word.
    randomize_tx_a();
    for (int k = 0; k < int'(NW); k++) slave_a[k*32 +: 32] = 32'hA5A5_A5A5;
    run_a();
    readback_a();

    // Out-of-range idle writes are ignored; start/writes during busy are ignored.
    randomize_tx_a();
    write_a(6'(40 + $urandom_range(0, 23)), $urandom, 1'b0);
    for (int k = 0; k < int'(NW); k++) slave_a[k*32 +: 32] = $urandom;
    start_a(1'b1);
    repeat (49) tick();
    check("busy_at_50", 32'(busy), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    write_a(6'd0, ~model_a[0], 1'b0);
    write_a(6'd45, $urandom, 1'b0);
    wait_done_a();
    tick();
    readback_a();
    run_a();

    // Start in the DONE cycle is ignored; start in the next IDLE cycle is taken.
    start_a(1'b1);
    wait_done_a();
    exp_a_q.push_back(pack_words(model_a));
    start = 1'b1;
    tick();
    check("start_in_done", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("start_after_done", 32'(busy), 32'd1);
    wait_done_a();
    tick();

    // Reset at busy cycle 100 aborts at once; a later transaction runs fully.
    randomize_tx_a();
    start_a(1'b0);
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_csb", 32'(spi_cs_b), 32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_sdi", 32'(spi_sdi), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    run_a();
    readback_a();

    // CLK_DIV=4 instance: phase timing and stream.
    for (int k = 0; k < int'(NW); k++) begin
      model_b[k] = $urandom;
      b_wr_en = 1'b1; b_wr_addr = 6'(k); b_wr_data = model_b[k];
      tick();
    end
    b_wr_en = 1'b0;
    exp_b_q.push_back(pack_words(model_b));
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    begin
      int n = 0;
      while (!b_done && n < BUDGET) begin tick(); n++; end
      if (!b_done) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout_b: no done within %0d cycles", BUDGET);
      end
    end
    repeat (3) tick();

    check("exp_a_drained", 32'(exp_a_q.size()), 32'd0);
    check("exp_b_drained", 32'(exp_b_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
